// File: rtl/knn_pkg.sv
// Shared types and constants for the KNN top-K sorter.
// The optional majority vote is enabled by defining KNN_TOPK_VOTE_EN.
package knn_pkg;

    // Default field widths; the sorter's width parameters must match these.
    localparam int unsigned TOPK_VAL_WIDTH   = 32;
    localparam int unsigned TOPK_IDX_WIDTH   = 16;
    localparam int unsigned TOPK_LABEL_WIDTH = 8;

    localparam logic [TOPK_VAL_WIDTH-1:0] TOPK_DIST_EMPTY = '1;
    localparam logic [TOPK_IDX_WIDTH-1:0] TOPK_IDX_EMPTY  = '1;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StVote,
        StDrain,
        StHold
    } topk_state_t;

    typedef struct packed {
        logic [TOPK_VAL_WIDTH-1:0]   distance;
        logic [TOPK_IDX_WIDTH-1:0]   index;
        logic [TOPK_LABEL_WIDTH-1:0] label;
        logic                        valid;
    } topk_slot_t;

    localparam topk_slot_t TOPK_EMPTY_SLOT = '{
        distance: TOPK_DIST_EMPTY,
        index:    TOPK_IDX_EMPTY,
        label:    '0,
        valid:    1'b0
    };

endpackage

// File: rtl/knn_vote_counter.sv
// Majority-vote helper: counts how many valid slots share the selected slot's label and
// keeps the best (highest count, earliest rank) label seen so far.
// Only instantiated when KNN_TOPK_VOTE_EN is defined.
module knn_vote_counter
    import knn_pkg::*;
#(
    parameter int unsigned K           = 4,
    parameter int unsigned LABEL_WIDTH = TOPK_LABEL_WIDTH,
    localparam int unsigned PtrW       = (K > 1) ? $clog2(K) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear_i,
    input  logic                            en_i,
    input  logic [PtrW-1:0]                 sel_i,
    input  logic [K-1:0][LABEL_WIDTH-1:0]   labels_i,
    input  logic [K-1:0]                    valid_i,
    output logic [LABEL_WIDTH-1:0]          best_label_o
);

    localparam int unsigned CntW = $clog2(K + 1);

    logic [CntW-1:0]        match_cnt;
    logic [CntW-1:0]        best_cnt_q, best_cnt_d;
    logic [LABEL_WIDTH-1:0] best_label_q, best_label_d;
    logic [LABEL_WIDTH-1:0] sel_label;

    // Count valid slots whose label equals the selected slot's label.
    always_comb begin
        sel_label = labels_i[sel_i];
        match_cnt = '0;
        for (int i = 0; i < K; i++) begin
            if (valid_i[i] && (labels_i[i] == sel_label)) begin
                match_cnt = match_cnt + 1'b1;
            end
        end
        if (!valid_i[sel_i]) begin
            match_cnt = '0;
        end
    end

    // Strictly-greater update so that on a tie the earlier rank keeps the win.
    always_comb begin
        best_cnt_d   = best_cnt_q;
        best_label_d = best_label_q;
        if (clear_i) begin
            best_cnt_d   = '0;
            best_label_d = '0;
        end else if (en_i && (match_cnt > best_cnt_q)) begin
            best_cnt_d   = match_cnt;
            best_label_d = sel_label;
        end
    end

    // Best-so-far registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_cnt_q   <= '0;
            best_label_q <= '0;
        end else begin
            best_cnt_q   <= best_cnt_d;
            best_label_q <= best_label_d;
        end
    end

    assign best_label_o = best_label_q;

endmodule

// File: rtl/knn_topk_sorter.sv
// Running top-K (smallest distance) list with nearest-first valid/ready drain.
// Define KNN_TOPK_VOTE_EN to add a K-cycle majority-vote phase before the drain.
module knn_topk_sorter
    import knn_pkg::*;
#(
    parameter int unsigned VAL_WIDTH   = TOPK_VAL_WIDTH,
    parameter int unsigned K           = 4,
    parameter int unsigned IDX_WIDTH   = TOPK_IDX_WIDTH,
    parameter int unsigned LABEL_WIDTH = TOPK_LABEL_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [VAL_WIDTH-1:0]   distance,
    input  logic                   distanceValid,
    input  logic [LABEL_WIDTH-1:0] label_in,
    input  logic                   done,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [VAL_WIDTH-1:0]   res_distance,
    output logic [IDX_WIDTH-1:0]   res_index,
    output logic [LABEL_WIDTH-1:0] res_label,
    output logic                   res_slot_valid,
    output logic                   res_last,
    output logic                   idx_overflow,
    output logic                   vote_valid,
    output logic [LABEL_WIDTH-1:0] vote_label
);

    localparam int unsigned PtrW = (K > 1) ? $clog2(K) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(K - 1);

    topk_state_t          state_q, state_d;
    topk_slot_t           slots_q [K];
    topk_slot_t           slots_d [K];
    topk_slot_t           base_slots [K];
    topk_slot_t           cand;
    logic [K-1:0]         qual;
    logic                 accept;
    logic [IDX_WIDTH-1:0] idx_q, idx_d, idx_base;
    logic                 ovf_q, ovf_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic                 beat_done;

    // Sorted insertion. Valid slots are ascending and empty slots trail them, so the
    // qualifying set is a thermometer: the first qualifying slot takes the candidate and
    // every later qualifying slot takes its predecessor.
    always_comb begin
        accept   = distanceValid && (start || (state_q == StCollect));
        idx_base = start ? '0 : idx_q;
        cand     = '{distance: distance, index: idx_base, label: label_in, valid: 1'b1};
        for (int i = 0; i < K; i++) begin
            base_slots[i] = start ? TOPK_EMPTY_SLOT : slots_q[i];
            qual[i]       = !base_slots[i].valid || (base_slots[i].distance > distance);
        end
        slots_d[0] = (accept && qual[0]) ? cand : base_slots[0];
        for (int i = 1; i < K; i++) begin
            slots_d[i] = base_slots[i];
            if (accept && qual[i]) begin
                slots_d[i] = qual[i-1] ? base_slots[i-1] : cand;
            end
        end
    end

    // Training-point index counter, saturating with a sticky overflow flag.
    always_comb begin
        idx_d = start ? '0 : idx_q;
        ovf_d = start ? 1'b0 : ovf_q;
        if (accept) begin
            if (&idx_base) begin
                idx_d = idx_base;
                ovf_d = 1'b1;
            end else begin
                idx_d = idx_base + 1'b1;
            end
        end
    end

`ifdef KNN_TOPK_VOTE_EN
    logic [PtrW-1:0]                 vote_cnt_q, vote_cnt_d;
    logic                            vote_valid_q, vote_valid_d;
    logic [K-1:0][LABEL_WIDTH-1:0]   slot_labels;
    logic [K-1:0]                    slot_valids;
    logic [LABEL_WIDTH-1:0]          best_label;
    logic                            vote_en;

    // Vote sequencing: walk ranks 0..K-1, then latch the result as valid.
    always_comb begin
        vote_en      = (state_q == StVote) && !start;
        vote_cnt_d   = vote_cnt_q;
        vote_valid_d = vote_valid_q;
        for (int i = 0; i < K; i++) begin
            slot_labels[i] = slots_q[i].label;
            slot_valids[i] = slots_q[i].valid;
        end
        if (start) begin
            vote_cnt_d   = '0;
            vote_valid_d = 1'b0;
        end else if (vote_en) begin
            if (vote_cnt_q == LastPtr) begin
                vote_cnt_d   = '0;
                vote_valid_d = 1'b1;
            end else begin
                vote_cnt_d = vote_cnt_q + 1'b1;
            end
        end
    end

    // Vote step counter and result-valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            vote_cnt_q   <= '0;
            vote_valid_q <= 1'b0;
        end else begin
            vote_cnt_q   <= vote_cnt_d;
            vote_valid_q <= vote_valid_d;
        end
    end

    knn_vote_counter #(
        .K           (K),
        .LABEL_WIDTH (LABEL_WIDTH)
    ) u_vote_counter (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start),
        .en_i         (vote_en),
        .sel_i        (vote_cnt_q),
        .labels_i     (slot_labels),
        .valid_i      (slot_valids),
        .best_label_o (best_label)
    );

    assign vote_valid = vote_valid_q;
    assign vote_label = vote_valid_q ? best_label : '0;
`else
    assign vote_valid = 1'b0;
    assign vote_label = '0;
`endif

    // Phase sequencing and drain handshake; start overrides everything else.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        res_valid = (state_q == StDrain);
        beat_done = res_valid && res_ready;
        if (start) begin
            state_d  = StCollect;
            rd_ptr_d = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StCollect: begin
                    if (done) begin
`ifdef KNN_TOPK_VOTE_EN
                        state_d = StVote;
`else
                        state_d = StDrain;
`endif
                    end
                end
                StVote: begin
`ifdef KNN_TOPK_VOTE_EN
                    if (vote_cnt_q == LastPtr) begin
                        state_d = StDrain;
                    end
`else
                    state_d = StDrain;
`endif
                end
                StDrain: begin
                    if (beat_done) begin
                        if (rd_ptr_q == LastPtr) begin
                            state_d  = StHold;
                            rd_ptr_d = '0;
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end
                    end
                end
                StHold: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Result beat is a straight view of the slot under the read pointer.
    always_comb begin
        res_distance   = slots_q[rd_ptr_q].distance;
        res_index      = slots_q[rd_ptr_q].index;
        res_label      = slots_q[rd_ptr_q].label;
        res_slot_valid = slots_q[rd_ptr_q].valid;
        res_last       = res_valid && (rd_ptr_q == LastPtr);
    end

    // State, list, counter and read-pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            for (int i = 0; i < K; i++) begin
                slots_q[i] <= TOPK_EMPTY_SLOT;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            slots_q  <= slots_d;
        end
    end

    assign idx_overflow = ovf_q;

endmodule

// File: tb/tb_knn_topk_sorter.sv
// Self-checking bench for knn_topk_sorter; honours KNN_TOPK_VOTE_EN when defined.
`timescale 1ns/1ps
module tb_knn_topk_sorter;

    localparam int K  = 4;
    localparam int VW = 32;
    localparam int IW = 16;
    localparam int LW = 8;
`ifdef KNN_TOPK_VOTE_EN
    localparam int VLAT = K;
`else
    localparam int VLAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [VW-1:0] distance = '0;
    logic          distanceValid = 1'b0;
    logic [LW-1:0] label_in = '0;
    logic          done = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [VW-1:0] res_distance;
    logic [IW-1:0] res_index;
    logic [LW-1:0] res_label;
    logic          res_slot_valid;
    logic          res_last;
    logic          idx_overflow;
    logic          vote_valid;
    logic [LW-1:0] vote_label;

    always #5 clk = ~clk;

    knn_topk_sorter #(
        .VAL_WIDTH   (VW),
        .K           (K),
        .IDX_WIDTH   (IW),
        .LABEL_WIDTH (LW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .distance       (distance),
        .distanceValid  (distanceValid),
        .label_in       (label_in),
        .done           (done),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_distance   (res_distance),
        .res_index      (res_index),
        .res_label      (res_label),
        .res_slot_valid (res_slot_valid),
        .res_last       (res_last),
        .idx_overflow   (idx_overflow),
        .vote_valid     (vote_valid),
        .vote_label     (vote_label)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [VW-1:0] d;
        logic [IW-1:0] i;
        logic [LW-1:0] l;
    } cand_t;

    cand_t         m_cands[$];
    int            m_next_idx = 0;
    bit            m_collect = 0;
    bit            m_draining = 0;
    bit            m_vote_valid = 0;
    int            m_wait = 0;
    int            m_beat = 0;
    logic [LW-1:0] m_vote_label = '0;
    bit            armed = 0;
    logic [VW-1:0] e_d [K];
    logic [IW-1:0] e_i [K];
    logic [LW-1:0] e_l [K];
    bit            e_v [K];

    // Expected ranking: stable selection of the K smallest candidates seen so far.
    function automatic void build_expect();
        bit used [64];
        for (int c = 0; c < 64; c++) used[c] = 0;
        for (int r = 0; r < K; r++) begin
            int best;
            best = -1;
            for (int c = 0; c < m_cands.size(); c++) begin
                if (!used[c] && (best < 0 || m_cands[c].d < m_cands[best].d)) best = c;
            end
            if (best >= 0) begin
                used[best] = 1;
                e_d[r] = m_cands[best].d;
                e_i[r] = m_cands[best].i;
                e_l[r] = m_cands[best].l;
                e_v[r] = 1;
            end else begin
                e_d[r] = '1;
                e_i[r] = '1;
                e_l[r] = '0;
                e_v[r] = 0;
            end
        end
    endfunction

    // Majority over valid entries; ties go to the label appearing at the lowest rank.
    function automatic logic [LW-1:0] vote_expect();
        int cnt [256];
        int first [256];
        int best_cnt;
        int best_rank;
        logic [LW-1:0] win;
        best_cnt = 0;
        best_rank = K;
        win = '0;
        for (int l = 0; l < 256; l++) begin
            cnt[l] = 0;
            first[l] = K;
        end
        for (int r = 0; r < K; r++) begin
            if (e_v[r]) begin
                if (cnt[e_l[r]] == 0) first[e_l[r]] = r;
                cnt[e_l[r]]++;
            end
        end
        for (int l = 0; l < 256; l++) begin
            if (cnt[l] > 0 && (cnt[l] > best_cnt || (cnt[l] == best_cnt && first[l] < best_rank)))
            begin
                best_cnt = cnt[l];
                best_rank = first[l];
                win = LW'(l);
            end
        end
        return win;
    endfunction

    always @(posedge clk) begin : model
        bit was_collect;
        bit was_drain;
        int was_wait;
        bit acc;
        if (reset) begin
            m_cands.delete();
            m_collect = 0;
            m_draining = 0;
            m_wait = 0;
            m_vote_valid = 0;
            m_beat = 0;
            m_next_idx = 0;
            armed = 1;
        end else begin
            was_collect = m_collect;
            was_drain = m_draining;
            was_wait = m_wait;
            acc = distanceValid && (start || was_collect);
            if (start) begin
                m_cands.delete();
                m_next_idx = 0;
                m_collect = 1;
                m_draining = 0;
                m_wait = 0;
                m_vote_valid = 0;
                m_beat = 0;
            end
            if (acc) begin
                m_cands.push_back('{d: distance,
                                    i: (m_next_idx > 65535) ? 16'hFFFF : IW'(m_next_idx),
                                    l: label_in});
                m_next_idx++;
            end
            if (!start) begin
                if (was_collect && done) begin
                    m_collect = 0;
                    build_expect();
                    if (VLAT > 0) m_wait = VLAT;
                    else m_draining = 1;
                end else if (was_wait > 0) begin
                    m_wait = was_wait - 1;
                    if (m_wait == 0) begin
                        m_draining = 1;
                        m_vote_valid = 1;
                        m_vote_label = vote_expect();
                    end
                end else if (was_drain && res_ready) begin
                    m_beat++;
                    if (m_beat == K) begin
                        m_draining = 0;
                        m_beat = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("res_valid", 64'(res_valid), 64'(m_draining));
            if (m_draining) begin
                chk("res_distance", 64'(res_distance), 64'(e_d[m_beat]));
                chk("res_index", 64'(res_index), 64'(e_i[m_beat]));
                chk("res_label", 64'(res_label), 64'(e_l[m_beat]));
                chk("res_slot_valid", 64'(res_slot_valid), 64'(e_v[m_beat]));
                chk("res_last", 64'(res_last), 64'(m_beat == K - 1));
            end
            chk("vote_valid", 64'(vote_valid), 64'(m_vote_valid));
            chk("vote_label", 64'(vote_label), 64'(m_vote_valid ? m_vote_label : 8'd0));
            chk("idx_overflow", 64'(idx_overflow), 64'(m_next_idx > 65535));
        end
    end

    // Accepted-beat recorder for the literal directed checks.
    logic [VW-1:0] q_d[$];
    logic [IW-1:0] q_i[$];
    logic [LW-1:0] q_l[$];
    logic          q_v[$];
    logic          q_last[$];

    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            q_d.push_back(res_distance);
            q_i.push_back(res_index);
            q_l.push_back(res_label);
            q_v.push_back(res_slot_valid);
            q_last.push_back(res_last);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        start = 0;
        distanceValid = 0;
        done = 0;
        distance = '0;
        label_in = '0;
    endtask

    task automatic clear_q();
        q_d.delete();
        q_i.delete();
        q_l.delete();
        q_v.delete();
        q_last.delete();
    endtask

    task automatic do_start();
        start = 1;
        cyc();
        start = 0;
    endtask

    task automatic send(input logic [VW-1:0] d, input logic [LW-1:0] l, input bit last);
        distanceValid = 1;
        distance = d;
        label_in = l;
        done = last;
        cyc();
        distanceValid = 0;
        done = 0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 50) begin
            cyc();
            n++;
        end
        chk(name, 64'(res_valid), 64'(1));
    endtask

    task automatic wait_hold(input string name);
        int n;
        n = 0;
        while ((m_draining || m_wait > 0) && n < 200) begin
            cyc();
            n++;
        end
        chk(name, 64'(n < 200), 64'(1));
    endtask

    // Rank 0 sits in the least-significant element of each packed vector.
    task automatic chk_beats(input string tag, input logic [K-1:0][VW-1:0] ed,
                             input logic [K-1:0][IW-1:0] ei, input logic [K-1:0] ev);
        chk({tag, "_count"}, 64'(q_d.size()), 64'(K));
        for (int r = 0; r < K; r++) begin
            if (r < q_d.size()) begin
                chk($sformatf("%s_dist%0d", tag, r), 64'(q_d[r]), 64'(ed[r]));
                chk($sformatf("%s_idx%0d", tag, r), 64'(q_i[r]), 64'(ei[r]));
                chk($sformatf("%s_sv%0d", tag, r), 64'(q_v[r]), 64'(ev[r]));
                chk($sformatf("%s_last%0d", tag, r), 64'(q_last[r]), 64'(r == K - 1));
            end
        end
    endtask

    function automatic logic [VW-1:0] rand_dist();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return '1;
        if (sel == 1) return VW'($urandom);
        return VW'($urandom_range(0, 15));
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int n;
        reset = 1;
        drive_idle();
        res_ready = 1;
        cyc();
        cyc();
        // Reset values.
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_distance", 64'(res_distance), 64'(32'hFFFF_FFFF));
        chk("rst_res_index", 64'(res_index), 64'(16'hFFFF));
        chk("rst_res_label", 64'(res_label), 64'(0));
        chk("rst_res_slot_valid", 64'(res_slot_valid), 64'(0));
        chk("rst_res_last", 64'(res_last), 64'(0));
        chk("rst_idx_overflow", 64'(idx_overflow), 64'(0));
        chk("rst_vote_valid", 64'(vote_valid), 64'(0));
        chk("rst_vote_label", 64'(vote_label), 64'(0));
        reset = 0;
        cyc();

        // Basic ranking.
        clear_q();
        do_start();
        send(50, 1, 0);
        send(10, 2, 0);
        send(30, 3, 0);
        send(20, 4, 0);
        send(40, 5, 1);
        n = 1;
        while (!res_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("t1_latency", 64'(n), 64'(VLAT + 1));
        wait_hold("t1_drain_timeout");
        chk_beats("t1", {32'd40, 32'd30, 32'd20, 32'd10}, {16'd4, 16'd2, 16'd3, 16'd1}, 4'b1111);
        if (q_l.size() == K) begin
            chk("t1_label0", 64'(q_l[0]), 64'(2));
            chk("t1_label3", 64'(q_l[3]), 64'(5));
        end

        // Partially filled list.
        clear_q();
        do_start();
        send(7, 9, 0);
        send(3, 8, 1);
        wait_hold("t2_drain_timeout");
        chk_beats("t2", {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd3},
                  {16'hFFFF, 16'hFFFF, 16'd0, 16'd1}, 4'b0011);
        if (q_l.size() == K) chk("t2_label0", 64'(q_l[0]), 64'(8));

        // Ties keep arrival order.
        clear_q();
        do_start();
        send(5, 1, 0);
        send(5, 2, 0);
        send(5, 3, 1);
        wait_hold("t3_drain_timeout");
        chk_beats("t3", {32'hFFFF_FFFF, 32'd5, 32'd5, 32'd5},
                  {16'hFFFF, 16'd2, 16'd1, 16'd0}, 4'b0111);

        // Back-pressure: ready 1,0,0,1.
        clear_q();
        do_start();
        send(4, 1, 0);
        send(3, 1, 0);
        send(2, 1, 0);
        send(1, 1, 1);
        wait_valid("t4_wait_valid");
        cyc();
        res_ready = 0;
        cyc();
        cyc();
        chk("t4_held_dist", 64'(res_distance), 64'(2));
        chk("t4_held_idx", 64'(res_index), 64'(2));
        chk("t4_held_valid", 64'(res_valid), 64'(1));
        res_ready = 1;
        wait_hold("t4_drain_timeout");
        chk_beats("t4", {32'd4, 32'd3, 32'd2, 32'd1}, {16'd0, 16'd1, 16'd2, 16'd3}, 4'b1111);

`ifdef KNN_TOPK_VOTE_EN
        // Vote tie goes to rank 0.
        clear_q();
        do_start();
        send(1, 2, 0);
        send(2, 7, 0);
        send(3, 2, 0);
        send(4, 7, 1);
        n = 1;
        while (!vote_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("t5_vote_latency", 64'(n), 64'(K + 1));
        chk("t5_vote_label", 64'(vote_label), 64'(2));
        chk("t5_res_valid_with_vote", 64'(res_valid), 64'(1));
        wait_hold("t5_drain_timeout");
`endif

        // Start mid-drain with a candidate in the start cycle.
        res_ready = 0;
        do_start();
        send(8, 1, 1);
        wait_valid("t6_wait_valid");
        start = 1;
        distanceValid = 1;
        distance = 9;
        label_in = 3;
        cyc();
        drive_idle();
        chk("t6_res_valid_dropped", 64'(res_valid), 64'(0));
        chk("t6_slot0_dist", 64'(res_distance), 64'(9));
        chk("t6_slot0_idx", 64'(res_index), 64'(0));
        clear_q();
        done = 1;
        cyc();
        done = 0;
        res_ready = 1;
        wait_hold("t6_drain_timeout");
        chk_beats("t6", {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9},
                  {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0}, 4'b0001);

        // Reset mid-drain.
        do_start();
        send(6, 1, 0);
        send(2, 1, 1);
        wait_valid("t7_wait_valid");
        reset = 1;
        cyc();
        chk("t7_reset_drops_valid", 64'(res_valid), 64'(0));
        reset = 0;
        cyc();

        // Randomized runs against the model.
        for (int run = 0; run < 40; run++) begin
            int nc;
            res_ready = 1;
            distanceValid = ($urandom_range(0, 3) == 0);
            distance = rand_dist();
            label_in = LW'($urandom_range(0, 3));
            done = ($urandom_range(0, 7) == 0);
            start = 1;
            cyc();
            drive_idle();
            nc = $urandom_range(0, 10);
            for (int c = 0; c < nc; c++) begin
                distanceValid = ($urandom_range(0, 2) != 0);
                distance = rand_dist();
                label_in = LW'($urandom_range(0, 3));
                done = (c == nc - 1);
                cyc();
            end
            if (nc == 0) begin
                done = 1;
                cyc();
            end
            drive_idle();
            n = 0;
            while ((m_draining || m_wait > 0) && n < 200) begin
                res_ready = $urandom_range(0, 1);
                distanceValid = $urandom_range(0, 1);
                distance = rand_dist();
                done = ($urandom_range(0, 3) == 0);
                if ((run % 7 == 3) && n == 2) begin
                    reset = 1;
                    cyc();
                    reset = 0;
                    n = 0;
                    break;
                end
                cyc();
                n++;
            end
            chk("rand_drain_timeout", 64'(n < 200), 64'(1));
            drive_idle();
            cyc();
        end

        res_ready = 1;
        cyc();
        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/knn_topk_sorter.md
# knn_topk_sorter

Downstream consumer of the distance accumulator's `distance`/`distanceValid` stream in the KNN accelerator. It keeps a running, rank-ordered list of the K smallest distances, with each distance's training-point index and label. When upstream signals `done`, it streams the K entries out nearest-first over a valid/ready handshake. Optionally, it first computes a majority-vote classification label.

## Interface
- `VAL_WIDTH`, 32, distance width; matches upstream `VAL_WIDTH`.
- `K`, 4, number of neighbours kept; range 1..16.
- `IDX_WIDTH`, 16, training-point index width.
- `LABEL_WIDTH`, 8, class label width.

Ports (reset is synchronous, active-high; clock is `clk`):
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: pulse that clears the list and index counter and enters COLLECT.
- `distance`, in, VAL_WIDTH: candidate distance.
- `distanceValid`, in, 1: `distance` is valid this cycle.
- `label_in`, in, LABEL_WIDTH: label of the candidate; cycle-aligned with `distanceValid`.
- `done`, in, 1: no further distances after this cycle.
- `res_valid`, out, 1: result beat valid.
- `res_ready`, in, 1: consumer accepts the beat.
- `res_distance`, out, VAL_WIDTH: ranked distance.
- `res_index`, out, IDX_WIDTH: index of that training point.
- `res_label`, out, LABEL_WIDTH: label of that training point.
- `res_slot_valid`, out, 1: slot was filled by a real candidate.
- `res_last`, out, 1: final beat (rank K-1).
- `idx_overflow`, out, 1: sticky; index counter saturated.
- `vote_valid`, out, 1: vote result available.
- `vote_label`, out, LABEL_WIDTH: majority label.

## Operation
- States: IDLE, COLLECT, VOTE, DRAIN, HOLD.
- Transitions:
  - IDLE goes to COLLECT on `start`.
  - COLLECT goes to VOTE on `done` (to DRAIN when voting is compiled out).
  - VOTE goes to DRAIN after K cycles.
  - DRAIN goes to HOLD after the `res_last` beat is accepted.
  - HOLD goes to COLLECT on `start`.
- `start` in any state clears the list, counter, `idx_overflow` and vote outputs, then enters COLLECT. `start` has priority over `done`.
- List contents: K slots, each holding {distance, index, label, slot_valid}.
- Cleared slot value: distance all-ones, index all-ones, label 0, slot_valid 0.
- Insertion, in COLLECT or in the `start` cycle, for each `distanceValid`:
  - Find the first slot whose stored distance is strictly greater than `distance`, or the first invalid slot.
  - Shift that slot and all later slots down by one; the old slot K-1 is discarded.
  - Write the candidate into the freed slot.
  - If no slot qualifies, drop the candidate.
  - One insertion per cycle with no stall; the block accepts back-to-back valids.
- Ties: equal distances keep arrival order, so the earlier index ranks nearer.
- Index counter:
  - 0 after `start`; the candidate arriving in the `start` cycle gets index 0.
  - Increments on each accepted `distanceValid`.
  - Saturates at all-ones and sets `idx_overflow`.
- `distanceValid` arriving in the same cycle as `done` is inserted. `distanceValid` in VOTE, DRAIN, HOLD or IDLE is ignored.
- DRAIN emits slots 0..K-1 in order, one beat per `res_valid && res_ready`. Unfilled slots are emitted with `res_slot_valid=0` and sentinel values.
- Comparisons are unsigned on VAL_WIDTH. No arithmetic widening is needed.

## Timing
- Reset values of all outputs are 0, except `res_distance` and `res_index`, which reset to all-ones. State resets to IDLE and all slots reset to sentinel.
- A distance sampled at cycle n is visible in the list at n+1.
- With `done` sampled at cycle d:
  - With voting compiled in: `vote_valid` and the first `res_valid` assert at d+K+1.
  - With voting compiled out: the first `res_valid` asserts at d+1.
- `res_*` hold stable while `res_valid && !res_ready`. A new beat follows on the cycle after acceptance.
- `vote_valid` and `vote_label` stay high and stable until `start` or `reset`.
- `reset` mid-drain drops `res_valid` on the next edge. No partial beat is emitted.

## Configuration
- Macro `KNN_TOPK_VOTE_EN`.
- Defined:
  - VOTE state runs for K cycles. Cycle j counts how many valid slots share slot j's label.
  - Winner is the label with the highest count; on a tie, the winner is the label whose slot has the lower rank.
  - If there are no valid slots, `vote_label` is 0.
- Undefined:
  - VOTE state is absent and COLLECT goes straight to DRAIN.
  - `vote_valid` and `vote_label` are tied to 0.

## Structure
- Package `knn_pkg`:
  - State enum `topk_state_t`.
  - Slot struct `topk_slot_t` with fields distance/index/label/valid.
  - Sentinel constants `TOPK_DIST_EMPTY` and `TOPK_IDX_EMPTY`.
- Sub-module `knn_vote_counter`:
  - Combinational match-count for one slot against all K slots.
  - Plus registered best-count/best-label tracking.
  - Instantiated only under `KNN_TOPK_VOTE_EN`.

## Test plan
1. K=4, `start`, then distances 50, 10, 30, 20, 40 with labels 1..5 and `done` on the last distance, `res_ready` held at 1 → beats (10,idx1,L2), (20,idx3,L4), (30,idx2,L3), (40,idx4,L5); `res_last` on the 4th beat.
2. Only two distances (7, 3), then `done` → beats 3, 7, then two sentinel beats with `res_slot_valid=0`.
3. Equal distances 5, 5, 5 at indices 0..2 → emitted in index order 0, 1, 2.
4. `res_ready` toggled 1,0,0,1 during drain → beat held unchanged while stalled; no beat lost or duplicated.
5. With vote enabled, labels {2,7,2,7} at ranks 0..3 → `vote_label=2` (count tie, rank 0 wins), asserted at d+5.
6. `start` asserted mid-DRAIN with `distanceValid=1`, distance 9 → list cleared; 9 stored at index 0; `res_valid` low on the next cycle.
